ntt_result_collector: RTL and testbench

Stream-side consumer for the NTT butterfly datapath: accepts butterfly output pairs beat by beat and tracks stage and pair counts itself. It discards intermediate-stage results and captures the final stage into an N-word buffer. It then drains the N coefficients over a valid/ready stream. It sits after the butterfly pipeline and is the read-out end of the transform, mirroring the controller that sequences operands into the datapath.

---
 rtl/ntt_result_collector.sv | 203 ++++++++++++++++++++
 tb/tb_ntt_result_collector.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_result_collector.sv
// ntt_result_collector
// ---------------------------------------------------------------------------
// Read-out end of the NTT butterfly datapath. Accepts butterfly output pairs
// beat by beat, counts stages and pairs itself, throws away every stage but
// the last, captures the last stage into an N-word buffer and then streams
// the N coefficients out over a valid/ready interface.
//
// Ports
//   clk        : clock, all state on the rising edge
//   reset      : asynchronous active-low reset
//   start      : one-cycle pulse, begins a transform (only honoured in IDLE)
//   in_valid   : butterfly pair present on in_a / in_b
//   in_ready   : collector takes a pair this cycle (registered state decode)
//   in_a, in_b : butterfly upper / lower output
//   out_valid  : coefficient present on out_data
//   out_ready  : downstream takes the coefficient
//   out_data   : coefficient value
//   out_index  : position 0..N-1 of out_data
//   out_last   : final coefficient of the transform
//   busy       : not idle
//   overflow   : sticky, a pair arrived while draining and was dropped
//
// Build option
//   NTT_OUT_BITREV_EN : when defined, coefficients leave in bit-reversed
//                       position order; out_index still reports the true
//                       position. Undefined: natural order.
// ---------------------------------------------------------------------------
module ntt_result_collector #(
    parameter  int RING_SIZE = 16,
    parameter  int DATA_W    = 16,
    localparam int IDX_W     = $clog2(RING_SIZE)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_index,
    output logic              out_last,
    output logic              busy,
    output logic              overflow
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_DRAIN  = 2'd2
    } state_e;

    localparam logic [IDX_W-2:0] PAIR_LAST  = (IDX_W-1)'(RING_SIZE/2 - 1);
    localparam logic [IDX_W-2:0] PAIR_ONE   = (IDX_W-1)'(1);
    localparam logic [IDX_W-1:0] STAGE_LAST = IDX_W'(IDX_W - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(RING_SIZE - 1);
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);

    state_e              state_q, state_d;
    logic [IDX_W-2:0]    pair_cnt_q, pair_cnt_d;
    logic [IDX_W-1:0]    stage_cnt_q, stage_cnt_d;
    logic [IDX_W-1:0]    drain_idx_q, drain_idx_d;
    logic                overflow_q, overflow_d;
    logic                mem_we_s;
    logic [IDX_W-1:0]    pos_s;
    logic [DATA_W-1:0]   mem_q [RING_SIZE];

    // Reverse the bit order of a drain index.
    function automatic logic [IDX_W-1:0] bitrev(input logic [IDX_W-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < IDX_W; i++) begin
            r[i] = v[IDX_W-1-i];
        end
        return r;
    endfunction

    // State and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            pair_cnt_q  <= '0;
            stage_cnt_q <= '0;
            drain_idx_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pair_cnt_q  <= pair_cnt_d;
            stage_cnt_q <= stage_cnt_d;
            drain_idx_q <= drain_idx_d;
            overflow_q  <= overflow_d;
        end
    end

    // Next-state, counter and buffer-write decode.
    always_comb begin
        state_d     = state_q;
        pair_cnt_d  = pair_cnt_q;
        stage_cnt_d = stage_cnt_q;
        drain_idx_d = drain_idx_q;
        overflow_d  = overflow_q;
        mem_we_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // in_valid is ignored here and never touches overflow.
                if (start) begin
                    state_d     = ST_ACCEPT;
                    pair_cnt_d  = '0;
                    stage_cnt_d = '0;
                    drain_idx_d = '0;
                    overflow_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCEPT: begin
                // in_ready is 1 in this state, so in_valid alone is a beat.
                if (in_valid) begin
                    if (stage_cnt_q == STAGE_LAST) begin
                        mem_we_s = 1'b1;
                    end else begin
                        mem_we_s = 1'b0;
                    end
                    if (pair_cnt_q == PAIR_LAST) begin
                        pair_cnt_d = '0;
                        if (stage_cnt_q == STAGE_LAST) begin
                            state_d     = ST_DRAIN;
                            drain_idx_d = '0;
                        end else begin
                            stage_cnt_d = stage_cnt_q + IDX_ONE;
                        end
                    end else begin
                        pair_cnt_d = pair_cnt_q + PAIR_ONE;
                    end
                end else begin
                    state_d = ST_ACCEPT;
                end
            end
            ST_DRAIN: begin
                if (in_valid) begin
                    overflow_d = 1'b1;
                end else begin
                    overflow_d = overflow_q;
                end
                if (out_ready) begin
                    if (drain_idx_q == IDX_LAST) begin
                        state_d     = ST_IDLE;
                        drain_idx_d = '0;
                    end else begin
                        drain_idx_d = drain_idx_q + IDX_ONE;
                    end
                end else begin
                    drain_idx_d = drain_idx_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Final-stage capture: pair k fills positions k and k+N/2. No reset,
    // the contents are only read after a full final stage has been written.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[{1'b0, pair_cnt_q}] <= in_a;
            mem_q[{1'b1, pair_cnt_q}] <= in_b;
        end
    end

    // Map the drain counter to the coefficient position being emitted.
    always_comb begin
        pos_s = '0;
`ifdef NTT_OUT_BITREV_EN
        pos_s = bitrev(drain_idx_q);
`else
        pos_s = drain_idx_q;
`endif
    end

    // Output decode; data/index forced to 0 outside DRAIN so reset shows 0.
    always_comb begin
        in_ready  = (state_q == ST_ACCEPT);
        out_valid = (state_q == ST_DRAIN);
        busy      = (state_q != ST_IDLE);
        overflow  = overflow_q;
        out_last  = 1'b0;
        out_index = '0;
        out_data  = '0;
        if (state_q == ST_DRAIN) begin
            out_last  = (drain_idx_q == IDX_LAST);
            out_index = pos_s;
            out_data  = mem_q[pos_s];
        end else begin
            out_last  = 1'b0;
            out_index = '0;
            out_data  = '0;
        end
    end

endmodule

// File: tb/tb_ntt_result_collector.sv
module tb_ntt_result_collector;

    logic        clk;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [2:0]  out_index;
    logic        out_last;
    logic        busy;
    logic        overflow;

    ntt_result_collector #(.RING_SIZE(8), .DATA_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .busy      (busy),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // Drain vector: out_ready to apply, expected drain counter, expected out_last.
    typedef struct {
        logic rdy;
        int   didx;
        logic last;
    } dv_t;

    dv_t         tbl [19];
    logic [15:0] exp_buf [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic logic [2:0] pos(input int d);
        logic [2:0] v;
        v = d[2:0];
`ifdef NTT_OUT_BITREV_EN
        return {v[0], v[1], v[2]};
`else
        return v;
`endif
    endfunction

    // Start a transform and feed 12 beats; optional idle gaps and a stray start.
    task automatic feed(input bit gaps, input int start_at);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("in_ready_after_start", in_ready, 1);
        chk("busy_after_start", busy, 1);
        chk("overflow_cleared", overflow, 0);
        for (int b = 0; b < 12; b++) begin
            chk("accept_in_ready", in_ready, 1);
            chk("accept_no_out_valid", out_valid, 0);
            in_valid = 1'b1;
            if (b / 4 == 2) begin
                in_a = 16'(b % 4 + 1);
                in_b = 16'(b % 4 + 16'h11);
            end else begin
                in_a = 16'hBAD0 + 16'(b);
                in_b = 16'hCAF0 + 16'(b);
            end
            start = (b == start_at);
            @(negedge clk);
            start = 1'b0;
            if (gaps && b != 11) begin
                in_valid = 1'b0;
                in_a = 16'h5A5A;
                in_b = 16'hA5A5;
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        chk("drain_starts", out_valid, 1);
        chk("drain_in_ready_low", in_ready, 0);
    endtask

    // Apply n drain vectors from the table; in_valid pulsed at entry ovf_at.
    task automatic run_drain(input int first, input int n, input int ovf_at);
        logic [2:0] p;
        for (int i = 0; i < n; i++) begin
            p = pos(tbl[first+i].didx);
            out_ready = tbl[first+i].rdy;
            in_valid  = (i == ovf_at);
            in_a = 16'hFFFF;
            in_b = 16'hFFFF;
            chk("out_valid", out_valid, 1);
            chk("out_index", out_index, p);
            chk("out_data", out_data, exp_buf[p]);
            chk("out_last", out_last, tbl[first+i].last);
            chk("overflow_drain", overflow, (ovf_at >= 0 && i > ovf_at));
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("idle_after_drain_busy", busy, 0);
        chk("idle_after_drain_valid", out_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 4; k++) begin
            exp_buf[k]   = 16'(k + 1);
            exp_buf[k+4] = 16'(k + 16'h11);
        end
        // Nominal drain: entries 0..7.
        for (int i = 0; i < 8; i++) tbl[i] = '{rdy: 1'b1, didx: i, last: (i == 7)};
        // Back-pressure drain: stall 3 cycles at drain index 2.
        tbl[8]  = '{rdy: 1'b1, didx: 0, last: 1'b0};
        tbl[9]  = '{rdy: 1'b1, didx: 1, last: 1'b0};
        tbl[10] = '{rdy: 1'b0, didx: 2, last: 1'b0};
        tbl[11] = '{rdy: 1'b0, didx: 2, last: 1'b0};
        tbl[12] = '{rdy: 1'b0, didx: 2, last: 1'b0};
        tbl[13] = '{rdy: 1'b1, didx: 2, last: 1'b0};
        for (int i = 3; i < 8; i++) tbl[11+i] = '{rdy: 1'b1, didx: i, last: (i == 7)};

        reset = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = 16'h0; in_b = 16'h0;
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_out_index", out_index, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // in_valid in IDLE is ignored.
        in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("idle_in_valid_no_ovf", overflow, 0);
        chk("idle_in_ready", in_ready, 0);
        chk("idle_busy", busy, 0);

        // Nominal.
        feed(1'b0, -1);
        run_drain(0, 8, -1);

        // Input stalls.
        feed(1'b1, -1);
        run_drain(0, 8, -1);

        // Ignored start after beat 6.
        feed(1'b0, 6);
        run_drain(0, 8, -1);

        // Back-pressure.
        out_ready = 1'b1;
        feed(1'b0, -1);
        run_drain(8, 11, -1);

        // Overflow: sticky through IDLE, cleared by next start (checked in feed).
        feed(1'b0, -1);
        run_drain(0, 8, 3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("overflow_sticky_idle", overflow, 1);
        end
        feed(1'b0, -1);
        run_drain(0, 8, -1);

        // Reset in the middle of DRAIN at drain index 5.
        feed(1'b0, -1);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) @(negedge clk);
        chk("pre_reset_index", out_index, pos(5));
        chk("pre_reset_data", out_data, exp_buf[pos(5)]);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_out_index", out_index, 0);
        chk("async_rst_out_data", out_data, 0);
        chk("async_rst_out_last", out_last, 0);
        chk("async_rst_in_ready", in_ready, 0);
        out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        feed(1'b0, -1);
        run_drain(0, 8, -1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
